// File: rtl/mpmc10_pkg.sv
// Shared types and constants for the mpmc10 multiport memory controller.
package mpmc10_pkg;

  typedef enum logic [1:0] {
    CMD_READ  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_RMW   = 2'd2,
    CMD_NOP   = 2'd3
  } mpmc10_cmd_e;

  typedef struct packed {
    mpmc10_cmd_e   cmd;
    logic [7:0]    tag;
    logic [31:0]   adr;
    logic [31:0]   sel;
    logic [255:0]  data;
  } faxi_readwrite_request256_t;

  localparam int MPMC10_REQ_FIFO_DEPTH = 16;
  localparam int MPMC10_REQ_FIFO_AFULL = 12;

endpackage

// File: rtl/mpmc10_fifo_ram.sv
// Generic DEPTH x WIDTH storage: synchronous write, asynchronous read, no reset.
module mpmc10_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents deliberately left unreset so this maps to distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mpmc10_req_fifo256.sv
// Per-port FWFT request buffer feeding the 256-bit request register stage.
module mpmc10_req_fifo256
  import mpmc10_pkg::*;
#(
  parameter int DEPTH        = MPMC10_REQ_FIFO_DEPTH,
  parameter int AFULL_THRESH = MPMC10_REQ_FIFO_AFULL
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  faxi_readwrite_request256_t i,
  input  logic                       rd_en,
  output faxi_readwrite_request256_t o,
  output logic                       o_valid,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       clr_err,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = $bits(faxi_readwrite_request256_t);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          o_valid_q, o_valid_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_ok_s;
  logic          pop_ok_s;
  logic [W-1:0]  ram_rdata_s;

  // Accept decisions only look at registered flags, so a pop on a full FIFO frees a slot for the push.
  always_comb begin
    pop_ok_s  = rd_en & o_valid_q;
    push_ok_s = wr_en & (~full_q | pop_ok_s);
  end

  // Next-state for pointers, occupancy and the flags decoded from it.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    o_valid_d = (count_d != CW'(0));
    full_d    = (count_d == CW'(DEPTH));
    afull_d   = (count_d >= CW'(AFULL_THRESH));
  end

  // Sticky error flags: a new event in the same cycle as clr_err keeps the flag set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_en & ~push_ok_s) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (rd_en & ~o_valid_q) begin
      underflow_d = 1'b1;
    end else if (clr_err) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // State register; reset discards every in-flight entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= AW'(0);
      rd_ptr_q    <= AW'(0);
      count_q     <= CW'(0);
      o_valid_q   <= 1'b0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      o_valid_q   <= o_valid_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  mpmc10_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok_s),
    .waddr (wr_ptr_q),
    .wdata (i),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata_s)
  );

  // Head is masked so stale storage never leaks out while empty.
  assign o           = faxi_readwrite_request256_t'(ram_rdata_s & {W{o_valid_q}});
  assign o_valid     = o_valid_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_mpmc10_req_fifo256.sv
// Directed bench for mpmc10_req_fifo256 with a queue-based reference model checked every cycle.
module tb_mpmc10_req_fifo256;
  import mpmc10_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int W     = $bits(faxi_readwrite_request256_t);

  logic clk = 1'b0;
  logic rst_n, wr_en, rd_en, clr_err;
  faxi_readwrite_request256_t i, o;
  logic o_valid, full, almost_full, overflow, underflow;
  logic [4:0] count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  faxi_readwrite_request256_t mq[$];
  bit m_ovf, m_unf;

  mpmc10_req_fifo256 #(.DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .i(i), .rd_en(rd_en), .o(o),
    .o_valid(o_valid), .full(full), .almost_full(almost_full), .count(count),
    .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic faxi_readwrite_request256_t mk(input logic [7:0] tag);
    faxi_readwrite_request256_t r;
    r.cmd  = CMD_WRITE;
    r.tag  = tag;
    r.adr  = {8'h40, tag, 8'h00, ~tag};
    r.sel  = {4{tag}};
    r.data = {32{tag ^ 8'h5A}};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of requests plus two sticky bits.
  always @(posedge clk) begin
    bit pop_ok, push_ok;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop_ok  = rd_en && (mq.size() > 0);
      push_ok = wr_en && ((mq.size() < DEPTH) || pop_ok);
      if (wr_en && !push_ok) m_ovf = 1'b1;
      else if (clr_err) m_ovf = 1'b0;
      if (rd_en && mq.size() == 0) m_unf = 1'b1;
      else if (clr_err) m_unf = 1'b0;
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(i);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", W'(count), W'(mq.size()));
      chk("o_valid", W'(o_valid), W'(mq.size() != 0));
      chk("full", W'(full), W'(mq.size() == DEPTH));
      chk("almost_full", W'(almost_full), W'(mq.size() >= AFULL));
      chk("overflow", W'(overflow), W'(m_ovf));
      chk("underflow", W'(underflow), W'(m_unf));
      chk("o", o, (mq.size() != 0) ? mq[0] : '0);
    end
  end

  task automatic step(input logic rn, input logic w, input logic r,
                      input logic [7:0] tag, input logic c);
    rst_n   = rn;
    wr_en   = w;
    rd_en   = r;
    i       = mk(tag);
    clr_err = c;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; i = mk(8'h00);
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst count", W'(count), W'(0));
    chk("rst o_valid", W'(o_valid), W'(0));
    chk("rst o", o, W'(0));
    chk("rst flags", W'({full, almost_full, overflow, underflow}), W'(0));

    // Fill with tags 0x00..0x0F.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b1, 1'b0, 8'(k), 1'b0);
      if (k == 10) chk("afull at 11", W'(almost_full), W'(0));
      if (k == 11) chk("afull at 12", W'(almost_full), W'(1));
      if (k == 14) chk("full at 15", W'(full), W'(0));
    end
    chk("fill full", W'(full), W'(1));
    chk("fill count", W'(count), W'(16));

    // Drain, expecting tags in order.
    for (int k = 0; k < 16; k++) begin
      chk("drain tag", W'(o.tag), W'(k));
      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    end
    chk("drain empty", W'(o_valid), W'(0));

    // Refill with 0x10..0x1F, then overflow with 0xAA.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b0, 8'(16 + k), 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'hAA, 1'b0);
    chk("ovf flag", W'(overflow), W'(1));
    chk("ovf count", W'(count), W'(16));
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf clear", W'(overflow), W'(0));

    // Push 0xBB and pop at full.
    step(1'b1, 1'b1, 1'b1, 8'hBB, 1'b0);
    chk("pp count", W'(count), W'(16));
    chk("pp full", W'(full), W'(1));
    chk("pp head", W'(o.tag), W'(8'h11));
    for (int k = 0; k < 16; k++) begin
      chk("pp drain tag", W'(o.tag), (k == 15) ? W'(8'hBB) : W'(8'h11 + k));
      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    end
    chk("pp empty", W'(o_valid), W'(0));

    // Empty push+pop: pop ignored, push accepted.
    step(1'b1, 1'b1, 1'b1, 8'hCC, 1'b0);
    chk("ep underflow", W'(underflow), W'(1));
    chk("ep count", W'(count), W'(1));
    chk("ep tag", W'(o.tag), W'(8'hCC));
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    chk("ep clear", W'(underflow), W'(0));

    // Interleaved traffic to wrap the pointers.
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'(k % 2), 8'(8'h40 + k), 1'b0);
    chk("wrap count", W'(count), W'(10));
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("wrap empty", W'(count), W'(0));

    // Reset mid-stream at count=5, with a push pending to show reset dominates.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 8'(8'h60 + k), 1'b0);
    chk("pre-rst count", W'(count), W'(5));
    step(1'b0, 1'b1, 1'b1, 8'h99, 1'b0);
    chk("mid-rst count", W'(count), W'(0));
    chk("mid-rst o_valid", W'(o_valid), W'(0));
    step(1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
    chk("post-rst count", W'(count), W'(1));
    chk("post-rst tag", W'(o.tag), W'(8'h77));
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
